// File: rtl/full_adder_pkg.sv
// Shared constants and types for the ripple-carry full adder slice.
package full_adder_pkg;

  // Operand width limits for full_adder instances.
  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH     = 64;

  // Output path selection; numerically equal to the REGISTERED parameter.
  typedef enum logic {
    FA_COMB = 1'b0,
    FA_REG  = 1'b1
  } fa_mode_e;

  // Width of the full {cout, sum} result for a given operand width.
  function automatic int fa_result_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell; the building block of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_sum;

  // Propagate term shared by the sum and the carry.
  assign half_sum = a ^ b;
  assign sum      = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from full_adder_cell instances, with
// either a registered (1-cycle latency) or purely combinational output path.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH      = FA_DEFAULT_WIDTH,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  localparam fa_mode_e MODE = fa_mode_e'(REGISTERED);

  // carry[i] feeds cell i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;

  assign carry[0]  = cin;
  assign cout_next = carry[WIDTH];

  // Ripple chain: each cell takes its carry from the cell below it.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    full_adder_cell u_cell (
      .a    (a[gi]),
      .b    (b[gi]),
      .cin  (carry[gi]),
      .sum  (sum_next[gi]),
      .cout (carry[gi+1])
    );
  end

  if (MODE == FA_REG) begin : g_reg
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             out_valid_reg;

    // Output registers: capture on valid, hold otherwise; reset clears at once.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_reg       <= '0;
        cout_reg      <= 1'b0;
        out_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= in_valid;
        if (in_valid) begin
          sum_reg  <= sum_next;
          cout_reg <= cout_next;
        end
      end
    end

    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign out_valid = out_valid_reg;
  end else begin : g_comb
    // Clock and reset have no function on the combinational path.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign sum       = sum_next;
    assign cout      = cout_next;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder in registered and combinational
// configurations at widths 1, 4 and 8.
`timescale 1ns/100ps
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // WIDTH=1 registered
  logic       a1r, b1r, cin1r, iv1r, sum1r, cout1r, ov1r;
  // WIDTH=1 combinational
  logic       a1c, b1c, cin1c, iv1c, sum1c, cout1c, ov1c;
  // WIDTH=4 registered
  logic [3:0] a4, b4, sum4;
  logic       cin4, iv4, cout4, ov4;
  // WIDTH=8 combinational
  logic [7:0] a8c, b8c, sum8c;
  logic       cin8c, iv8c, cout8c, ov8c;
  // WIDTH=8 registered
  logic [7:0] a8r, b8r, sum8r;
  logic       cin8r, iv8r, cout8r, ov8r;

  // Scoreboards of expected {cout, sum}
  logic [1:0] q1r[$];
  logic [4:0] q4[$];
  logic [8:0] q8[$];

  full_adder #(.WIDTH(1), .REGISTERED(1'b1)) u_w1r (
    .clk(clk), .rst_n(rst_n), .a(a1r), .b(b1r), .cin(cin1r), .in_valid(iv1r),
    .sum(sum1r), .cout(cout1r), .out_valid(ov1r));
  full_adder #(.WIDTH(1), .REGISTERED(1'b0)) u_w1c (
    .clk(clk), .rst_n(rst_n), .a(a1c), .b(b1c), .cin(cin1c), .in_valid(iv1c),
    .sum(sum1c), .cout(cout1c), .out_valid(ov1c));
  full_adder #(.WIDTH(4), .REGISTERED(1'b1)) u_w4r (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
    .sum(sum4), .cout(cout4), .out_valid(ov4));
  full_adder #(.WIDTH(8), .REGISTERED(1'b0)) u_w8c (
    .clk(clk), .rst_n(rst_n), .a(a8c), .b(b8c), .cin(cin8c), .in_valid(iv8c),
    .sum(sum8c), .cout(cout8c), .out_valid(ov8c));
  full_adder #(.WIDTH(8), .REGISTERED(1'b1)) u_w8r (
    .clk(clk), .rst_n(rst_n), .a(a8r), .b(b8r), .cin(cin8r), .in_valid(iv8r),
    .sum(sum8r), .cout(cout8r), .out_valid(ov8r));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int         s;
    logic [1:0] e1;
    logic [4:0] e4;
    logic [8:0] e8;
    logic [8:0] last8;

    rst_n = 1'b1;
    {a1r, b1r, cin1r, iv1r} = '0;
    {a1c, b1c, cin1c, iv1c} = '0;
    a4 = '0; b4 = '0; cin4 = 1'b0; iv4 = 1'b0;
    a8c = '0; b8c = '0; cin8c = 1'b0; iv8c = 1'b0;
    a8r = '0; b8r = '0; cin8r = 1'b0; iv8r = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_w1", {ov1r, cout1r, sum1r}, 64'd0);
    check("reset_w4", {ov4, cout4, sum4}, 64'd0);
    check("reset_w8", {ov8r, cout8r, sum8r}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational WIDTH=1 truth table, 10 ns apart
    for (int i = 0; i < 8; i++) begin
      {a1c, b1c, cin1c} = 3'(i);
      iv1c = ~iv1c;
      #10;
      s = int'(a1c) + int'(b1c) + int'(cin1c);
      check($sformatf("w1c_tt%0d", i), {cout1c, sum1c}, 64'(s));
      check($sformatf("w1c_valid%0d", i), ov1c, iv1c);
    end

    // Registered WIDTH=1: capture then hold
    @(negedge clk);
    a1r = 1'b1; b1r = 1'b1; cin1r = 1'b0; iv1r = 1'b1;
    q1r.push_back(2'b10);
    @(posedge clk); #1;
    check("w1r_valid", ov1r, 64'd1);
    e1 = q1r.pop_front();
    check("w1r_110", {cout1r, sum1r}, 64'(e1));
    @(negedge clk);
    a1r = 1'b0; b1r = 1'b0; iv1r = 1'b0;
    @(posedge clk); #1;
    check("w1r_hold_valid", ov1r, 64'd0);
    check("w1r_hold", {cout1r, sum1r}, 64'(e1));

    // WIDTH=4 boundaries back to back, with WIDTH=1 running alongside
    @(negedge clk);
    a1r = 1'b1; b1r = 1'b0; cin1r = 1'b1; iv1r = 1'b1;
    q1r.push_back(2'b10);
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1; iv4 = 1'b1;
    q4.push_back(5'h10);
    @(posedge clk); #1;
    e1 = q1r.pop_front();
    check("w1r_101", {ov1r, cout1r, sum1r}, 64'({1'b1, e1}));
    e4 = q4.pop_front();
    check("w4_F_0_1", {ov4, cout4, sum4}, 64'({1'b1, e4}));
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    q4.push_back(5'h1F);
    @(posedge clk); #1;
    e4 = q4.pop_front();
    check("w4_F_F_1", {ov4, cout4, sum4}, 64'({1'b1, e4}));

    // Asynchronous reset pulse between edges
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_w1", {ov1r, cout1r, sum1r}, 64'd0);
    check("async_rst_w4", {ov4, cout4, sum4}, 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    a1r = 1'b0; b1r = 1'b1; cin1r = 1'b1; iv1r = 1'b1;
    q1r.push_back(2'b10);
    iv4 = 1'b0;
    @(posedge clk); #1;
    e1 = q1r.pop_front();
    check("post_rst_w1", {ov1r, cout1r, sum1r}, 64'({1'b1, e1}));
    check("post_rst_w4_idle", {ov4, cout4, sum4}, 64'd0);
    @(negedge clk);
    iv1r = 1'b0;

    // Combinational WIDTH=8
    a8c = 8'd200; b8c = 8'd100; cin8c = 1'b0; iv8c = 1'b1;
    #1;
    check("w8c_200_100", {ov8c, cout8c, sum8c}, {55'd0, 1'b1, 9'h12C});
    for (int i = 0; i < 6; i++) begin
      a8c = 8'($urandom); b8c = 8'($urandom); cin8c = 1'($urandom);
      #1;
      s = int'(a8c) + int'(b8c) + int'(cin8c);
      check($sformatf("w8c_rand%0d", i), {cout8c, sum8c}, 64'(s));
    end

    // Registered WIDTH=8 random stream, valid every cycle
    last8 = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a8r = 8'($urandom); b8r = 8'($urandom); cin8r = 1'($urandom); iv8r = 1'b1;
      s = int'(a8r) + int'(b8r) + int'(cin8r);
      q8.push_back(9'(s));
      @(posedge clk); #1;
      check($sformatf("w8r_valid%0d", i), ov8r, 64'd1);
      if (q8.size() == 0) begin
        check("w8r_scoreboard_empty", 64'd1, 64'd0);
      end else begin
        e8 = q8.pop_front();
        last8 = e8;
        check($sformatf("w8r_vec%0d", i), {cout8r, sum8r}, 64'(e8));
      end
    end
    @(negedge clk);
    iv8r = 1'b0; a8r = ~a8r;
    @(posedge clk); #1;
    check("w8r_idle_valid", ov8r, 64'd0);
    check("w8r_idle_hold", {cout8r, sum8r}, 64'(last8));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 Parameter: REGISTERED, default 1, selects the output path; 1 = registered outputs, 0 = purely combinational outputs.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: a  input  WIDTH  addend A, unsigned.
REQ-007 Port: b  input  WIDTH  addend B, unsigned.
REQ-008 Port: cin  input  1  carry-in.
REQ-009 Port: in_valid  input  1  qualifies a, b and cin.
REQ-010 Port: sum  output  WIDTH  sum bits.
REQ-011 Port: cout  output  1  carry-out, the MSB of the (WIDTH+1)-bit result.
REQ-012 Port: out_valid  output  1  qualifies sum and cout.
REQ-013 Ports a, b, cin, sum and cout SHALL keep that relative order after clk and rst_n.

Function
REQ-014 {cout, sum} SHALL equal a + b + cin, computed exactly at WIDTH+1 bits, with no truncation except wrap into cout.
REQ-015 For WIDTH=1: sum = a XOR b XOR cin; cout = (a AND b) OR (cin AND (a XOR b)).
REQ-016 The result SHALL be formed by a ripple chain of 1-bit cells.
REQ-017 Cell i SHALL take carry-in from cell i-1; cell 0 SHALL take cin; cout SHALL be taken from cell WIDTH-1.
REQ-018 REGISTERED=1: on a rising clk edge with in_valid=1, sum and cout SHALL capture the result of the current inputs; latency is 1 cycle.
REQ-019 REGISTERED=1: out_valid SHALL be in_valid delayed by one clk cycle.
REQ-020 REGISTERED=1: on an edge with in_valid=0, sum and cout SHALL hold their previous values.
REQ-021 REGISTERED=0: sum and cout SHALL follow a, b and cin combinationally with zero latency.
REQ-022 REGISTERED=0: out_valid SHALL equal in_valid; clk and rst_n are unused.
REQ-023 All-ones operands with cin=1 SHALL give sum = all-ones and cout = 1; a = all-ones, b = 0, cin = 1 SHALL give sum = 0 and cout = 1.
REQ-024 Back-to-back valid inputs SHALL be accepted every cycle; there is no backpressure.
REQ-025 No X SHALL propagate to the outputs when the inputs are known.

Reset
REQ-026 While rst_n=0 (REGISTERED=1), sum, cout and out_valid SHALL be 0, asynchronously, without waiting for a clock edge.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight result; the first edge after deassertion with in_valid=1 SHALL produce a valid result one cycle later.

Structure
REQ-028 A shared package full_adder_pkg SHALL hold FA_DEFAULT_WIDTH=1 and FA_MAX_WIDTH=64.
REQ-029 One sub-module, full_adder_cell (a, b, cin -> sum, cout, combinational), SHALL be instantiated WIDTH times by a generate loop.
REQ-030 A single always_ff block with asynchronous reset SHALL hold the output registers.

Verification
REQ-031 WIDTH=1: apply all 8 combinations of a, b, cin, 10 ns apart -> (a,b,cin)=(0,0,0)->sum 0, cout 0; (0,1,1)->sum 0, cout 1; (1,0,0)->sum 1, cout 0; (1,1,1)->sum 1, cout 1.
REQ-032 WIDTH=1, REGISTERED=1: in_valid=1 with (1,1,0) at edge N -> sum=0, cout=1, out_valid=1 after edge N; in_valid=0 at edge N+1 -> outputs hold, out_valid=0.
REQ-033 WIDTH=4: a=4'hF, b=4'h0, cin=1 -> sum=4'h0, cout=1; a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1.
REQ-034 rst_n=0 pulsed between edges while out_valid=1 -> sum=0, cout=0, out_valid=0 immediately, without a clock edge.
REQ-035 REGISTERED=0, WIDTH=8: a=8'd200, b=8'd100, cin=0 -> sum=8'd44, cout=1 in the same delta, with no clock.
REQ-036 WIDTH=8, random stream of 1000 vectors with in_valid=1 every cycle -> {cout,sum} equals a+b+cin, checked by a reference model with 1-cycle alignment.
